// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter.
// Round-robin grant locked for the whole cyc burst, plus a stall watchdog
// that terminates a hung strobe with an error to the granted master.
module wb_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  // slave side
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  // grant status
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  // The counter holds completed stall cycles, so the current stall cycle is
  // r_cnt+1; the watchdog fires on the TIMEOUT-th consecutive stall cycle.
  localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               r_state;
  logic                 r_last_gnt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_gnt;

  logic w_sel0;
  logic w_sel1;
  logic w_cyc;
  logic w_stb;
  logic w_term;
  logic w_stall;
  logic w_timeout;

  assign w_sel0    = (r_state == ST_GNT0);
  assign w_sel1    = (r_state == ST_GNT1);
  assign w_cyc     = (w_sel0 & m0_cyc_i) | (w_sel1 & m1_cyc_i);
  assign w_stb     = (w_sel0 & m0_stb_i) | (w_sel1 & m1_stb_i);
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = w_stb & ~w_term;
  assign w_timeout = w_stall & (r_cnt == LP_CNT_LAST);

  // Slave-side mux: follows the granted master, all zero when idle
  assign s_cyc_o = w_cyc;
  assign s_stb_o = w_stb & ~w_timeout;
  assign s_we_o  = (w_sel0 & m0_we_i) | (w_sel1 & m1_we_i);
  assign s_adr_o = w_sel0 ? m0_adr_i : (w_sel1 ? m1_adr_i : 32'h0);
  assign s_sel_o = w_sel0 ? m0_sel_i : (w_sel1 ? m1_sel_i : 4'h0);
  assign s_dat_o = w_sel0 ? m0_dat_i : (w_sel1 ? m1_dat_i : 32'h0);

  // Master-side return paths: terminations gated by the master's own strobe
  assign m0_dat_o = w_sel0 ? s_dat_i : 32'h0;
  assign m0_ack_o = w_sel0 & m0_stb_i & s_ack_i;
  assign m0_err_o = w_sel0 & ((m0_stb_i & s_err_i) | w_timeout);
  assign m0_rty_o = w_sel0 & m0_stb_i & s_rty_i;

  assign m1_dat_o = w_sel1 ? s_dat_i : 32'h0;
  assign m1_ack_o = w_sel1 & m1_stb_i & s_ack_i;
  assign m1_err_o = w_sel1 & ((m1_stb_i & s_err_i) | w_timeout);
  assign m1_rty_o = w_sel1 & m1_stb_i & s_rty_i;

  assign gnt_o = r_gnt;

  // Arbitration FSM, grant register and watchdog counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
      r_cnt      <= '0;
      r_gnt      <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            if (r_last_gnt) begin
              r_state <= ST_GNT0;
              r_gnt   <= 2'b01;
            end else begin
              r_state <= ST_GNT1;
              r_gnt   <= 2'b10;
            end
          end else if (m0_cyc_i) begin
            r_state <= ST_GNT0;
            r_gnt   <= 2'b01;
          end else if (m1_cyc_i) begin
            r_state <= ST_GNT1;
            r_gnt   <= 2'b10;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b0;
            r_gnt      <= 2'b00;
            r_cnt      <= '0;
          end else begin
            r_cnt <= (w_stall && !w_timeout) ? r_cnt + 1'b1 : '0;
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 2'b00;
            r_cnt      <= '0;
          end else begin
            r_cnt <= (w_stall && !w_timeout) ? r_cnt + 1'b1 : '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 2'b00;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// compared against a behavioural owner/stall-count model.
module tb_wb_arbiter;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  // behavioural model: owner -1 = nobody, 0/1 = master index
  int md_owner, md_last, md_stall;
  logic [1:0]  e_gnt;
  logic        e_scyc, e_sstb, e_swe, e_stalled, e_to;
  logic [31:0] e_sadr, e_sdat, e_m0_dat, e_m1_dat;
  logic [3:0]  e_ssel;
  logic        e_m0_ack, e_m0_err, e_m0_rty, e_m1_ack, e_m1_err, e_m1_rty;

  wb_arbiter #(.TIMEOUT(TMO), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    md_owner = -1;
    md_last  = 1;
    md_stall = 0;
  endfunction

  // expected outputs for the current owner, stall count and inputs
  function automatic void model_eval();
    logic c, s, term;
    c = (md_owner == 0) ? m0_cyc_i : ((md_owner == 1) ? m1_cyc_i : 1'b0);
    s = (md_owner == 0) ? m0_stb_i : ((md_owner == 1) ? m1_stb_i : 1'b0);
    term      = s_ack_i | s_err_i | s_rty_i;
    e_stalled = s && !term;
    e_to      = e_stalled && (md_stall + 1 == TMO);
    e_gnt     = (md_owner == 0) ? 2'b01 : ((md_owner == 1) ? 2'b10 : 2'b00);
    e_scyc    = c;
    e_sstb    = s && !e_to;
    e_swe     = (md_owner == 0) ? m0_we_i  : ((md_owner == 1) ? m1_we_i  : 1'b0);
    e_sadr    = (md_owner == 0) ? m0_adr_i : ((md_owner == 1) ? m1_adr_i : 32'h0);
    e_ssel    = (md_owner == 0) ? m0_sel_i : ((md_owner == 1) ? m1_sel_i : 4'h0);
    e_sdat    = (md_owner == 0) ? m0_dat_i : ((md_owner == 1) ? m1_dat_i : 32'h0);
    e_m0_dat  = (md_owner == 0) ? s_dat_i : 32'h0;
    e_m1_dat  = (md_owner == 1) ? s_dat_i : 32'h0;
    e_m0_ack  = (md_owner == 0) && m0_stb_i && s_ack_i;
    e_m0_rty  = (md_owner == 0) && m0_stb_i && s_rty_i;
    e_m0_err  = (md_owner == 0) && ((m0_stb_i && s_err_i) || e_to);
    e_m1_ack  = (md_owner == 1) && m1_stb_i && s_ack_i;
    e_m1_rty  = (md_owner == 1) && m1_stb_i && s_rty_i;
    e_m1_err  = (md_owner == 1) && ((m1_stb_i && s_err_i) || e_to);
  endfunction

  // advance the model by one rising edge using the currently held inputs
  function automatic void model_clock();
    model_eval();
    if (rst_i) begin
      model_reset();
    end else if (md_owner < 0) begin
      md_stall = 0;
      if (m0_cyc_i && m1_cyc_i) md_owner = (md_last == 1) ? 0 : 1;
      else if (m0_cyc_i)        md_owner = 0;
      else if (m1_cyc_i)        md_owner = 1;
    end else if (!((md_owner == 0) ? m0_cyc_i : m1_cyc_i)) begin
      md_last  = md_owner;
      md_owner = -1;
      md_stall = 0;
    end else if (e_stalled && !e_to) begin
      md_stall = md_stall + 1;
    end else begin
      md_stall = 0;
    end
  endfunction

  task automatic tick();
    model_clock();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    s_ack_i = 1; s_dat_i = 32'hA5A5_5A5A;
    model_reset();
    @(negedge clk_i); @(negedge clk_i); #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt_o); end
    total++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin bad++; $display("FAIL reset_sctl got=%b want=000", {s_cyc_o, s_stb_o, s_we_o}); end
    total++; if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== 6'b0) begin bad++; $display("FAIL reset_term got=%b want=000000", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}); end
    total++; if ({m0_dat_o, m1_dat_o} !== 64'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", {m0_dat_o, m1_dat_o}); end
    @(negedge clk_i);
    idle_inputs();
    rst_i = 0;
    tick();
  endtask

  task automatic test_m0_read();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h1000_0004; m0_sel_i = 4'hF;
    #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL read_latency got=%b want=00", gnt_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL read_gnt got=%b want=01", gnt_o); end
    total++; if (s_adr_o !== 32'h1000_0004 || s_stb_o !== 1'b1) begin bad++; $display("FAIL read_adr got=%h/%b want=10000004/1", s_adr_o, s_stb_o); end
    total++; if (m0_ack_o !== 1'b0) begin bad++; $display("FAIL read_early_ack got=%b want=0", m0_ack_o); end
    tick();
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    total++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got=%b/%h want=1/deadbeef", m0_ack_o, m0_dat_o); end
    total++; if ({m1_ack_o, m1_err_o, m1_rty_o} !== 3'b0 || m1_dat_o !== 32'h0) begin bad++; $display("FAIL read_m1_quiet got=%b/%h want=000/0", {m1_ack_o, m1_err_o, m1_rty_o}, m1_dat_o); end
    tick();
    idle_inputs();
    #1;
    total++; if (gnt_o !== 2'b01 || s_cyc_o !== 1'b0) begin bad++; $display("FAIL read_drop got=%b/%b want=01/0", gnt_o, s_cyc_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL read_idle got=%b want=00", gnt_o); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick(); #1; model_eval();
    total++; if (gnt_o !== 2'b01 || gnt_o !== e_gnt) begin bad++; $display("FAIL tie_first got=%b want=01", gnt_o); end
    tick();
    m0_cyc_i = 0;
    tick(); #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL tie_idle got=%b want=00", gnt_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL tie_second got=%b want=10", gnt_o); end
    m1_cyc_i = 0;
    tick(); tick();
  endtask

  task automatic test_alternate();
    logic       p0, p1;
    logic [1:0] prev_g, last_nz;
    int         grants, n0, n1;
    p0 = 0; p1 = 0; prev_g = 2'b00; last_nz = 2'b00; grants = 0; n0 = 0; n1 = 0;
    s_ack_i = 1;
    for (int cyc = 0; cyc < 200 && grants < 20; cyc++) begin
      m0_cyc_i = !p0; m0_stb_i = !p0;
      m1_cyc_i = !p1; m1_stb_i = !p1;
      #1; model_eval();
      total++; if (gnt_o !== e_gnt) begin bad++; $display("FAIL alt_gnt cycle=%0d got=%b want=%b", cyc, gnt_o, e_gnt); end
      if (gnt_o != 2'b00 && gnt_o != prev_g) begin
        grants++;
        if (gnt_o == 2'b01) n0++; else n1++;
        total++; if (gnt_o === last_nz || prev_g !== 2'b00) begin bad++; $display("FAIL alt_order got=%b prev=%b last=%b", gnt_o, prev_g, last_nz); end
        last_nz = gnt_o;
      end
      prev_g = gnt_o;
      p0 = e_m0_ack; p1 = e_m1_ack;
      tick();
    end
    total++; if (grants < 20 || n0 < 10 || n1 < 10) begin bad++; $display("FAIL alt_fairness got=%0d/%0d/%0d want=20/10/10", grants, n0, n1); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_burst();
    int acks, gap;
    logic drop;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h4000_0000; m1_sel_i = 4'b0001;
    m1_dat_i = $urandom;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1;
    acks = 0; gap = 0; drop = 0;
    for (int cyc = 0; cyc < 40 && !drop; cyc++) begin
      s_ack_i = (gap >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1; model_eval();
      total++; if (gnt_o !== 2'b10 || s_we_o !== 1'b1 || s_sel_o !== 4'b0001 || s_adr_o !== m1_adr_i || s_dat_o !== m1_dat_i) begin bad++; $display("FAIL burst_bus got=%b/%b/%b/%h want=10/1/0001/%h", gnt_o, s_we_o, s_sel_o, s_adr_o, m1_adr_i); end
      total++; if (m1_ack_o !== e_m1_ack || m0_ack_o !== 1'b0) begin bad++; $display("FAIL burst_ack got=%b/%b want=%b/0", m1_ack_o, m0_ack_o, e_m1_ack); end
      if (e_m1_ack) begin acks++; gap = 0; end else gap++;
      tick();
      if (e_m1_ack) begin m1_adr_i = m1_adr_i + 32'd4; m1_dat_i = $urandom; end
      if (acks == 4) begin drop = 1; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0; end
    end
    total++; if (acks != 4) begin bad++; $display("FAIL burst_count got=%0d want=4", acks); end
    #1;
    total++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b0) begin bad++; $display("FAIL burst_drop got=%b/%b want=10/0", gnt_o, s_cyc_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL burst_idle got=%b want=00", gnt_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL burst_handover got=%b want=01", gnt_o); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_watchdog();
    m0_cyc_i = 1;
    tick(); #1;
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL wd_gnt got=%b want=01", gnt_o); end
    tick();
    m0_stb_i = 1;
    for (int k = 1; k <= 10; k++) begin
      #1; model_eval();
      total++;
      if (m0_err_o !== (k == TMO) || s_stb_o !== (k != TMO) || m0_err_o !== e_m0_err) begin
        bad++; $display("FAIL wd_stall k=%0d got err=%b stb=%b want err=%b stb=%b", k, m0_err_o, s_stb_o, (k == TMO), (k != TMO));
      end
      tick();
    end
    m0_stb_i = 0;
    tick();
    m0_stb_i = 1;
    for (int k = 1; k <= TMO; k++) begin
      s_ack_i = (k == TMO);
      #1;
      total++;
      if (m0_err_o !== 1'b0 || m0_ack_o !== (k == TMO) || s_stb_o !== 1'b1) begin
        bad++; $display("FAIL wd_ack_wins k=%0d got err=%b ack=%b stb=%b want err=0 ack=%b stb=1", k, m0_err_o, m0_ack_o, s_stb_o, (k == TMO));
      end
      tick();
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h4000_0010;
    tick(); #1;
    total++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b/%b want=10/1", gnt_o, s_cyc_o); end
    #1;
    s_ack_i = 1;
    rst_i = 1;
    #1;
    total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00) begin bad++; $display("FAIL rmid_async got=%b/%b/%b want=0/0/00", s_cyc_o, s_stb_o, gnt_o); end
    total++; if ({m1_ack_o, m1_err_o, m1_rty_o} !== 3'b000) begin bad++; $display("FAIL rmid_noterm got=%b want=000", {m1_ack_o, m1_err_o, m1_rty_o}); end
    model_reset();
    @(negedge clk_i);
    rst_i = 0;
    idle_inputs();
    m0_cyc_i = 1; m1_cyc_i = 1;
    #1;
    total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL rmid_idle got=%b want=00", gnt_o); end
    tick(); #1;
    total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL rmid_tie got=%b want=01", gnt_o); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    int r, timeouts;
    timeouts = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 7) != 0); else m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 7) != 0); else m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m0_adr_i = $urandom; m0_sel_i = 4'($urandom); m0_dat_i = $urandom;
      m1_we_i = 1'($urandom); m1_adr_i = $urandom; m1_sel_i = 4'($urandom); m1_dat_i = $urandom;
      r = int'($urandom_range(0, 31));
      s_ack_i = (r < 5);
      s_err_i = (r == 5);
      s_rty_i = (r == 6);
      s_dat_i = $urandom;
      #1; model_eval();
      if (e_to) timeouts++;
      total++; if ({gnt_o, s_cyc_o, s_stb_o, s_we_o} !== {e_gnt, e_scyc, e_sstb, e_swe}) begin bad++; $display("FAIL rnd_ctl cycle=%0d got=%b want=%b", cyc, {gnt_o, s_cyc_o, s_stb_o, s_we_o}, {e_gnt, e_scyc, e_sstb, e_swe}); end
      total++; if ({s_adr_o, s_sel_o, s_dat_o} !== {e_sadr, e_ssel, e_sdat}) begin bad++; $display("FAIL rnd_sbus cycle=%0d got=%h want=%h", cyc, {s_adr_o, s_sel_o, s_dat_o}, {e_sadr, e_ssel, e_sdat}); end
      total++; if ({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o} !== {e_m0_ack, e_m0_err, e_m0_rty, e_m1_ack, e_m1_err, e_m1_rty}) begin bad++; $display("FAIL rnd_term cycle=%0d got=%b want=%b", cyc, {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, {e_m0_ack, e_m0_err, e_m0_rty, e_m1_ack, e_m1_err, e_m1_rty}); end
      total++; if ({m0_dat_o, m1_dat_o} !== {e_m0_dat, e_m1_dat}) begin bad++; $display("FAIL rnd_rdat cycle=%0d got=%h want=%h", cyc, {m0_dat_o, m1_dat_o}, {e_m0_dat, e_m1_dat}); end
      tick();
    end
    total++; if (timeouts == 0) begin bad++; $display("FAIL rnd_timeouts got=0 want>0"); end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    model_reset();
    @(negedge clk_i);
    test_reset();
    test_m0_read();
    test_tie();
    test_alternate();
    test_burst();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master, one-slave shared-bus Wishbone arbiter.
- Sits between the CPU (master 0) and a second bus master such as a DMA or debug port (master 1), and the slave-side decoded bus feeding memory and gpio.
- Grants are round-robin and locked for the whole of a master's cyc_i burst.
- Includes a stall watchdog that terminates hung cycles with an error.

Parameters:
- TIMEOUT, 255: cycles a granted strobe may wait without ack/err/rty before the watchdog fires; legal range 1..65535.
- CNT_WIDTH, 16: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_adr_i  in  32  master 0 address
- m0_sel_i  in  4  master 0 byte selects
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  master 0 read data
- m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 terminations
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
- s_adr_o  out  32  slave-side address
- s_sel_o  out  4  slave-side byte selects
- s_dat_o  out  32  slave-side write data
- s_dat_i  in  32  slave-side read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave-side terminations
- gnt_o  out  2  one-hot current grant, 00 when idle

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high on rst_i.
  - While rst_i is high: state=IDLE, last_gnt=1, watchdog count=0.
  - All s_* outputs, m*_ack/err/rty_o and gnt_o are 0.
  - m*_dat_o is 0.
- State machine: IDLE, GNT0, GNT1.
- IDLE:
  - Requests are m0_cyc_i and m1_cyc_i.
  - Only one requesting: go to that master's GNT state.
  - Both requesting: grant the master that is not last_gnt, so master 0 wins the first tie after reset.
  - Neither requesting: stay in IDLE.
  - Arbitration latency is one cycle: the grant becomes visible on the cycle after the request is first seen in IDLE.
- GNTn:
  - Slave bus outputs equal master n's signals combinationally; s_cyc_o = mn_cyc_i.
  - mn_dat_o = s_dat_i.
  - mn_ack_o, mn_err_o, mn_rty_o = the slave's terminations gated by mn_stb_i.
  - The other master sees all outputs 0.
  - Grant is held as long as mn_cyc_i stays high, including across multiple strobes. There is no preemption.
  - On the first edge where mn_cyc_i is low: go to IDLE and set last_gnt=n.
  - The granted master dropping cyc_i mid-strobe ends the cycle; the arbiter does not wait for ack.
- Watchdog:
  - In GNTn with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i, the counter increments.
  - Any termination, or stb low, clears the counter.
  - When the counter equals TIMEOUT:
    - mn_err_o is forced to 1 for exactly that cycle.
    - s_stb_o is forced to 0 that cycle.
    - The counter clears.
  - The grant is kept; the master is expected to drop cyc_i.
  - A slave termination arriving in the same cycle as the timeout wins: it is passed through, no error is injected, and the counter clears.
- Outputs:
  - gnt_o is registered: 01 in GNT0, 10 in GNT1, 00 in IDLE.
  - s_* outputs are combinational from the grant state and are 0 in IDLE.
- Reset mid-transfer:
  - s_cyc_o/s_stb_o fall immediately, combinationally through the state.
  - No termination is issued to the interrupted master.
- Simultaneous events: cyc_i dropping on the granted master while the other master is requesting gives one IDLE cycle, then a grant to the other master. There are no back-to-back grants without passing through IDLE.

Test Plan:
- Reset, then m0 single read (adr 0x1000_0004, slave ack after 2 cycles, s_dat_i=0xDEADBEEF) -> gnt_o=01 one cycle after cyc; m0_dat_o=0xDEADBEEF with m0_ack_o; m1 outputs stay 0.
- Both cyc_i rise on the same edge after reset -> m0 granted first; after m0 drops cyc, one IDLE cycle, then gnt_o=10.
- Both masters requesting continuously with 1-strobe bursts -> grants alternate 01,00,10,00,01...; no starvation over 20 transactions.
- m1 issues a 4-strobe burst with cyc held (write 0x4000_0000, sel=0001) while m0 requests -> m1 keeps the grant for all 4 acks; m0 is granted only after m1 drops cyc.
- TIMEOUT=8, slave never acks -> m0_err_o pulses exactly on cycle 8 of the stalled strobe and s_stb_o=0 that cycle; an ack on cycle 8 instead gives ack with no err.
- Assert rst_i mid-burst of m1 -> s_cyc_o=0 without a clock edge; after release, state is IDLE and m0 wins the next tie.
